// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has priority over debug writes,
// with a post-reset / on-demand clear sequence and debug starvation stall.
module rf_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            dbg_valid,
  output logic            dbg_ready,
  input  logic [AW-1:0]   dbg_rd,
  input  logic [XLEN-1:0] dbg_data,
  input  logic            init_start,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            stall_req,
  output logic            init_done,
  output logic            err_wb_drop
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  localparam logic [AW-1:0] FIRST = AW'(1);
  localparam logic [7:0]    LIM  = 8'(STARVE_LIMIT);

  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic [7:0]    starve_cnt, starve_nx;
  logic          err_nx;
  logic          wb_busy;
  logic          xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      idx         <= FIRST;
      starve_cnt  <= '0;
      err_wb_drop <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      starve_cnt  <= starve_nx;
      err_wb_drop <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    starve_nx = starve_cnt;
    err_nx    = err_wb_drop;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    dbg_ready = 1'b0;
    stall_req = 1'b1;
    init_done = 1'b0;
    wb_busy   = wb_we && (wb_rd != '0);
    xfer      = 1'b0;
    // outputs stay in their safe defaults while rst is high
    if (!rst) begin
      unique case (state)
        CLEAR: begin
          rf_we     = 1'b1;
          rf_waddr  = idx;
          starve_nx = '0;
          if (wb_busy) err_nx = 1'b1;
          if (init_start) begin
            idx_nx = FIRST;
          end else if (idx == LAST) begin
            state_nx = IDLE;
          end else begin
            idx_nx = idx + AW'(1);
          end
        end
        IDLE: begin
          init_done = 1'b1;
          dbg_ready = !wb_busy;
          xfer      = dbg_valid && !wb_busy;
          stall_req = (starve_cnt == LIM);
          if (wb_busy) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
          end else if (xfer) begin
            rf_we    = (dbg_rd != '0);
            rf_waddr = dbg_rd;
            rf_wdata = dbg_data;
          end
          if (init_start) begin
            state_nx  = CLEAR;
            idx_nx    = FIRST;
            starve_nx = '0;
          end else if (dbg_valid && wb_busy) begin
            starve_nx = (starve_cnt == LIM) ? LIM : starve_cnt + 8'd1;
          end else begin
            starve_nx = '0;
          end
        end
        default: state_nx = CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus random traffic,
// checked each cycle against a behavioural model and a shadow register file.
module tb_rf_write_arbiter;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int LIM  = 4;

  logic            clk;
  logic            rst;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            dbg_valid;
  logic            dbg_ready;
  logic [AW-1:0]   dbg_rd;
  logic [XLEN-1:0] dbg_data;
  logic            init_start;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            stall_req;
  logic            init_done;
  logic            err_wb_drop;

  rf_write_arbiter #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_rd(dbg_rd), .dbg_data(dbg_data),
    .init_start(init_start),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .init_done(init_done),
    .err_wb_drop(err_wb_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // behavioural model state
  bit m_idle;
  int m_idx;
  int m_blk;
  bit m_err;
  logic [XLEN-1:0] exp_rf [NREG];
  logic [XLEN-1:0] dut_rf [NREG];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic eval();
    bit busy, xf, rdy, st, dn, we;
    logic [AW-1:0] a;
    logic [XLEN-1:0] d;
    #1;
    busy = 0; xf = 0; a = '0; d = '0; we = 0;
    if (rst) begin
      rdy = 0; st = 1; dn = 0;
    end else if (!m_idle) begin
      we = 1; a = AW'(m_idx); rdy = 0; st = 1; dn = 0;
    end else begin
      busy = wb_we && (wb_rd != 0);
      rdy = !busy;
      xf = dbg_valid && rdy;
      st = (m_blk >= LIM);
      dn = 1;
      if (busy) begin
        we = 1; a = wb_rd; d = wb_data;
      end else if (xf) begin
        we = (dbg_rd != 0); a = dbg_rd; d = dbg_data;
      end
    end
    chk("rf_we", rf_we, we);
    chk("rf_waddr", rf_waddr, a);
    chk("rf_wdata", rf_wdata, d);
    chk("dbg_ready", dbg_ready, rdy);
    chk("stall_req", stall_req, st);
    chk("init_done", init_done, dn);
    chk("err_wb_drop", err_wb_drop, m_err);
    if (we) exp_rf[a] = d;
    if (rf_we === 1'b1) dut_rf[rf_waddr] = rf_wdata;
  endtask

  task automatic adv();
    if (rst) begin
      m_idle = 0; m_idx = 1; m_blk = 0; m_err = 0;
    end else if (!m_idle) begin
      if (wb_we && wb_rd != 0) m_err = 1;
      m_blk = 0;
      if (init_start) m_idx = 1;
      else if (m_idx == NREG - 1) m_idle = 1;
      else m_idx++;
    end else if (init_start) begin
      m_idle = 0; m_idx = 1; m_blk = 0;
    end else if (dbg_valid && wb_we && wb_rd != 0) begin
      m_blk = (m_blk < LIM) ? m_blk + 1 : LIM;
    end else begin
      m_blk = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  initial begin
    checks = 0; errors = 0;
    m_idle = 0; m_idx = 1; m_blk = 0; m_err = 0;
    for (int i = 0; i < NREG; i++) begin
      exp_rf[i] = '0; dut_rf[i] = '0;
    end
    rst = 1; wb_we = 0; wb_rd = '0; wb_data = '0;
    dbg_valid = 0; dbg_rd = '0; dbg_data = '0; init_start = 0;
    @(posedge clk);
    @(negedge clk);
    step();
    step();
    rst = 0;
    for (int i = 1; i < NREG; i++) begin
      eval(); chk("clr_addr", rf_waddr, i); adv();
    end
    eval();
    chk("done_c32", init_done, 1);
    chk("stall_c32", stall_req, 0);
    adv();

    wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    dbg_valid = 1; dbg_rd = 6; dbg_data = 32'h12345678;
    eval();
    chk("wbp_addr", rf_waddr, 5);
    chk("wbp_data", rf_wdata, 32'hDEADBEEF);
    chk("wbp_rdy", dbg_ready, 0);
    adv();
    wb_we = 0;
    eval(); chk("dbg_addr", rf_waddr, 6); chk("dbg_rdy", dbg_ready, 1); adv();

    wb_we = 1; wb_rd = 0; dbg_rd = 7;
    eval(); chk("x0wb_rdy", dbg_ready, 1); chk("x0wb_addr", rf_waddr, 7); adv();
    wb_we = 0; dbg_rd = 0;
    eval(); chk("x0dbg_rdy", dbg_ready, 1); chk("x0dbg_we", rf_we, 0); adv();
    dbg_valid = 0;

    wb_we = 1; wb_rd = 3; wb_data = 32'h0BADF00D;
    dbg_valid = 1; dbg_rd = 11; dbg_data = 32'hA5A5A5A5;
    for (int k = 1; k <= 6; k++) begin
      eval(); chk("starve_stall", stall_req, (k >= 5)); adv();
    end
    wb_we = 0;
    eval();
    chk("starve_rdy", dbg_ready, 1);
    chk("starve_addr", rf_waddr, 11);
    chk("starve_hold", stall_req, 1);
    adv();
    dbg_valid = 0;
    eval(); chk("starve_drop", stall_req, 0); adv();

    dbg_valid = 1; dbg_rd = 12; dbg_data = 32'hCAFE0012; init_start = 1;
    eval(); chk("reclr_xfer", rf_waddr, 12); chk("reclr_we", rf_we, 1); adv();
    init_start = 0; dbg_valid = 0; wb_rd = 9;
    for (int i = 1; i < NREG; i++) begin
      wb_we = (i == 10);
      eval();
      chk("reclr_rdy", dbg_ready, 0);
      chk("reclr_stall", stall_req, 1);
      chk("reclr_addr", rf_waddr, i);
      adv();
    end
    wb_we = 0;
    eval(); chk("reclr_done", init_done, 1); chk("err_sticky", err_wb_drop, 1); adv();

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom % 60) == 0;
      init_start = ($urandom % 50) == 0;
      wb_we = ($urandom % 4) != 0;
      wb_rd = AW'($urandom % 8);
      wb_data = $urandom;
      dbg_valid = ($urandom % 3) != 0;
      dbg_rd = AW'($urandom % 8);
      dbg_data = $urandom;
      step();
    end
    for (int i = 0; i < NREG; i++) chk("shadow_rf", dut_rf[i], exp_rf[i]);

    rst = 1; init_start = 0; wb_we = 0; dbg_valid = 0;
    step();
    rst = 0;
    for (int i = 1; i <= 9; i++) step();
    eval(); chk("mid_idx10", rf_waddr, 10); adv();
    rst = 1;
    eval(); chk("mid_rst_we", rf_we, 0); adv();
    rst = 0;
    eval(); chk("mid_restart", rf_waddr, 1); adv();
    for (int i = 2; i < NREG; i++) step();
    eval(); chk("final_done", init_done, 1); chk("err_cleared", err_wb_drop, 0); adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Controller for the integer register file's single write port. It shares the port between the writeback stage and a debug/loader requester, and runs a clear sequence after reset or on demand that zeroes x1..x(NREG-1). It sits between the WB stage and the register file, and drives a stall request to the pipeline hazard logic. The register file samples its write port on the falling clock edge, so every rf_* output is settled within the high phase of the cycle.

## Interface

- XLEN, 32, data width
- NREG, 32, number of architectural registers (power of two, ≥ 4)
- AW, 5, register address width, log2(NREG)
- STARVE_LIMIT, 8, number of blocked debug cycles before stall_req is forced (1..255)

- clk  in  1  clock, rising-edge state updates
- rst  in  1  reset, synchronous, active-high
- wb_we  in  1  writeback write enable
- wb_rd  in  AW  writeback destination register
- wb_data  in  XLEN  writeback data
- dbg_valid  in  1  debug write request
- dbg_ready  out  1  debug write accepted this cycle (combinational)
- dbg_rd  in  AW  debug destination register
- dbg_data  in  XLEN  debug write data
- init_start  in  1  one-cycle pulse that requests a new clear sequence
- rf_we  out  1  register-file write enable (combinational)
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  XLEN  register-file write data
- stall_req  out  1  request to freeze the pipeline front end
- init_done  out  1  high when the file is cleared and the block is in IDLE
- err_wb_drop  out  1  sticky flag: a WB write arrived during CLEAR and was dropped

## Operation

- States:
  - CLEAR: walks idx from 1 to NREG-1.
  - IDLE: normal arbitration.
- Reset:
  - While rst is high: state=CLEAR, idx=1, starve_cnt=0, err_wb_drop=0.
  - Outputs while rst is high: rf_we=0, dbg_ready=0, stall_req=1, init_done=0, rf_waddr=0, rf_wdata=0.
- CLEAR state:
  - Each cycle: rf_we=1, rf_waddr=idx, rf_wdata=0, stall_req=1, dbg_ready=0, init_done=0.
  - When idx=NREG-1, the next state is IDLE; otherwise idx increments.
- WB write during CLEAR (wb_we=1 and wb_rd≠0):
  - The write is dropped and err_wb_drop is set.
  - err_wb_drop clears only on rst.
- IDLE arbitration, WB has fixed priority:
  - wb_busy = wb_we && (wb_rd≠0).
  - If wb_busy: rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data.
  - dbg_ready = !wb_busy.
  - A debug transfer occurs when dbg_valid && dbg_ready. That cycle: rf_we = (dbg_rd≠0), rf_waddr=dbg_rd, rf_wdata=dbg_data.
  - A debug write to x0 is accepted and discarded.
  - With no writer: rf_we=0, and rf_waddr/rf_wdata hold 0.
  - WB writes to x0 never assert rf_we.
- Starvation control, IDLE only:
  - starve_cnt increments, saturating at STARVE_LIMIT, in each cycle where dbg_valid && !dbg_ready.
  - starve_cnt clears on a debug transfer or when dbg_valid=0.
  - stall_req = (starve_cnt == STARVE_LIMIT) in IDLE.
- Re-clear:
  - init_start in IDLE makes the next state CLEAR, with idx=1 and starve_cnt=0.
  - A debug transfer in that same cycle still completes.
  - init_start during CLEAR restarts idx at 1.
- Simultaneous init_start and rst: rst wins.
- init_done = (state == IDLE).

## Timing

- Clear sequence length: exactly NREG-1 cycles after rst falls.
  - With NREG=32, x1 is written in cycle 1 and x31 in cycle 31.
  - In cycle 32 the block is in IDLE, init_done=1 and stall_req=0 (absent starvation).
- WB path latency: 0 cycles. rf_* follows wb_* combinationally in the same cycle.
- Debug handshake:
  - dbg_rd, dbg_data and dbg_valid must stay stable until the cycle with dbg_valid && dbg_ready.
  - The write lands at that cycle's falling edge.
- stall_req from starvation:
  - Asserts in the cycle after starve_cnt reaches STARVE_LIMIT.
  - Drops in the cycle after the transfer.
- rst mid-CLEAR or mid-handshake aborts the operation. No partial debug write is issued after rst rises.

## Test plan

- Reset release: hold rst for 2 cycles, then release -> rf_we=1 with rf_waddr=1..31 and rf_wdata=0 over 31 consecutive cycles; init_done=1 in cycle 32.
- WB priority: in IDLE, wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, with dbg_valid=1, dbg_rd=6 -> rf_waddr=5, rf_wdata=0xDEADBEEF, dbg_ready=0. On the next cycle with wb_we=0, rf_waddr=6 and dbg_ready=1.
- x0 filtering:
  - WB to x0 with dbg_valid=1, dbg_rd=7 -> dbg_ready=1, rf_waddr=7.
  - Debug write to x0 -> dbg_ready=1, rf_we=0.
- Starvation: STARVE_LIMIT=4, wb_we=1 to x3 every cycle, dbg_valid held -> stall_req=1 from cycle 5. After wb_we drops, the transfer occurs and stall_req returns to 0 the next cycle.
- Re-clear: init_start in IDLE -> 31 clear cycles, dbg_ready=0 and stall_req=1 throughout. A wb_we to x9 inside that window -> err_wb_drop=1, remaining set after returning to IDLE.
- Reset mid-CLEAR: assert rst at idx=10 -> rf_we=0 while rst is high. After release, the sequence restarts at x1.
